// File: rtl/rgb2gray_pipe.sv
// -----------------------------------------------------------------------------
// rgb2gray_pipe
//
// Fully pipelined RGB-to-grayscale converter with valid/ready handshakes on
// both sides. Each pixel carries its own coefficient-set selector and an
// end-of-line marker. The luma result is rounded to nearest using unsigned
// Q16 coefficients.
//
// Pipeline (one pixel per cycle, 3 cycles input-to-output when unstalled):
//   S1  register R, G, B, mode, last, v1
//   S2  pr = R*cr, pg = G*cg, pb = B*cb   (coefficients picked by S1 mode)
//   S3  gray = (pr + pg + pb + 0.5) >> 16, registered onto the outputs
//
// Flow control: the whole pipeline moves together when the output register
// is empty or is being drained (advance = ~out_valid | out_ready). Otherwise
// every stage holds. in_ready equals advance, so nothing is dropped or
// duplicated under backpressure.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (0 = reset)
//   in_valid   input pixel valid
//   in_ready   block can accept a pixel this cycle
//   red_in     red channel   [DATA_W-1:0]
//   green_in   green channel [DATA_W-1:0]
//   blue_in    blue channel  [DATA_W-1:0]
//   mode_in    coefficient set: 0 BT.601, 1 BT.709, 2 average, 3 green only
//   last_in    end-of-line marker travelling with the pixel
//   out_valid  gray_out valid
//   out_ready  downstream accepts gray_out
//   gray_out   luma result [DATA_W-1:0]
//   last_out   last_in delayed with its own pixel
//   busy       any pipeline stage holds a valid pixel
//
// Parameters:
//   DATA_W  bits per colour channel and per gray output (4..16)
//   COEF_W  width of the unsigned Q16 coefficients (17, so 65536 fits)
// -----------------------------------------------------------------------------
module rgb2gray_pipe #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] red_in,
  input  logic [DATA_W-1:0] green_in,
  input  logic [DATA_W-1:0] blue_in,
  input  logic [1:0]        mode_in,
  input  logic              last_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] gray_out,
  output logic              last_out,
  output logic              busy
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int SUM_W  = PROD_W + 2;

  typedef enum logic [1:0] {
    MODE_BT601 = 2'd0,
    MODE_BT709 = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_GREEN = 2'd3
  } mode_e;

  // Stage 1 registers
  logic              v1;
  logic [DATA_W-1:0] s1_red;
  logic [DATA_W-1:0] s1_green;
  logic [DATA_W-1:0] s1_blue;
  mode_e             s1_mode;
  logic              s1_last;

  // Stage 2 registers
  logic              v2;
  logic [PROD_W-1:0] s2_pr;
  logic [PROD_W-1:0] s2_pg;
  logic [PROD_W-1:0] s2_pb;
  logic              s2_last;

  // Combinational helpers
  logic              advance;
  logic [COEF_W-1:0] coef_r;
  logic [COEF_W-1:0] coef_g;
  logic [COEF_W-1:0] coef_b;
  logic [SUM_W-1:0]  sum;

  // A stage may move only if the output slot is free or being emptied;
  // all stages share this single enable so pixel order is preserved.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;
  assign busy     = v1 | v2 | out_valid;

  // Coefficient lookup for the pixel sitting in S1. Every set sums to 65536,
  // so the rounded result can never exceed 2^DATA_W-1.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a coefficient
    // unassigned, which would otherwise infer a latch.
    coef_r = '0;
    coef_g = '0;
    coef_b = '0;
    unique case (s1_mode)
      MODE_BT601: begin
        coef_r = COEF_W'(19595);
        coef_g = COEF_W'(38470);
        coef_b = COEF_W'(7471);
      end
      MODE_BT709: begin
        coef_r = COEF_W'(13933);
        coef_g = COEF_W'(46871);
        coef_b = COEF_W'(4732);
      end
      MODE_AVG: begin
        coef_r = COEF_W'(21845);
        coef_g = COEF_W'(21845);
        coef_b = COEF_W'(21846);
      end
      MODE_GREEN: begin
        coef_r = '0;
        coef_g = COEF_W'(65536);
        coef_b = '0;
      end
      default: ;
    endcase
  end

  // Adding one half in Q16 turns the truncating shift into round-to-nearest.
  always_comb begin
    sum = SUM_W'(s2_pr) + SUM_W'(s2_pg) + SUM_W'(s2_pb) + SUM_W'(32768);
  end

  // S1: capture the incoming pixel and its sideband.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every data register is reset as well as the valid bits, so the
    // outputs read as zero after reset and no stale value is ever visible.
    if (!rst) begin
      v1       <= 1'b0;
      s1_red   <= '0;
      s1_green <= '0;
      s1_blue  <= '0;
      s1_mode  <= MODE_BT601;
      s1_last  <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments so every stage samples the values its
      // predecessor held before this edge, regardless of block ordering.
      v1       <= in_valid;
      s1_red   <= red_in;
      s1_green <= green_in;
      s1_blue  <= blue_in;
      s1_mode  <= mode_e'(mode_in);
      s1_last  <= last_in;
    end
  end

  // S2: three unsigned products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2      <= 1'b0;
      s2_pr   <= '0;
      s2_pg   <= '0;
      s2_pb   <= '0;
      s2_last <= 1'b0;
    end else if (advance) begin
      v2      <= v1;
      s2_pr   <= PROD_W'(s1_red)   * PROD_W'(coef_r);
      s2_pg   <= PROD_W'(s1_green) * PROD_W'(coef_g);
      s2_pb   <= PROD_W'(s1_blue)  * PROD_W'(coef_b);
      s2_last <= s1_last;
    end
  end

  // S3: rounded sum onto the output registers. Empty slots from S2 clear
  // out_valid, so bubbles are never presented downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      gray_out  <= '0;
      last_out  <= 1'b0;
    end else if (advance) begin
      out_valid <= v2;
      gray_out  <= DATA_W'(sum >> 16);
      last_out  <= s2_last;
    end
  end

endmodule

// File: tb/tb_rgb2gray_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for rgb2gray_pipe: directed vectors with hand-computed results
// for an 8-bit instance, plus a 10-bit instance for the width checks.
// -----------------------------------------------------------------------------
module tb_rgb2gray_pipe;

  typedef struct {
    logic [15:0] r;
    logic [15:0] g;
    logic [15:0] b;
    logic [1:0]  m;
    logic        l;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0] gray;
    logic       last;
    int         cyc;
  } exp_t;

  // 8-bit instance
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] red, green, blue;
  logic [1:0] mode;
  logic       last_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gray;
  logic       last_out;
  logic       busy;

  // 10-bit instance
  logic       in_valid10;
  logic       in_ready10;
  logic [9:0] red10, green10, blue10;
  logic [1:0] mode10;
  logic       out_valid10;
  logic       out_ready10;
  logic [9:0] gray10;
  logic       last_out10;
  logic       busy10;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   mon_en   = 1'b0;
  bit   check_lat = 1'b0;
  bit   was_stall = 1'b0;
  int   stall_cycles = 0;
  logic [31:0] held;
  exp_t exp_q[$];

  rgb2gray_pipe #(.DATA_W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .red_in   (red),
    .green_in (green),
    .blue_in  (blue),
    .mode_in  (mode),
    .last_in  (last_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gray_out (gray),
    .last_out (last_out),
    .busy     (busy)
  );

  rgb2gray_pipe #(.DATA_W(10)) dut10 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid10),
    .in_ready (in_ready10),
    .red_in   (red10),
    .green_in (green10),
    .blue_in  (blue10),
    .mode_in  (mode10),
    .last_in  (1'b0),
    .out_valid(out_valid10),
    .out_ready(out_ready10),
    .gray_out (gray10),
    .last_out (last_out10),
    .busy     (busy10)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_gray(input int r, input int g, input int b, input int m);
    int cr, cg, cb;
    case (m)
      0:       begin cr = 19595; cg = 38470; cb = 7471;  end
      1:       begin cr = 13933; cg = 46871; cb = 4732;  end
      2:       begin cr = 21845; cg = 21845; cb = 21846; end
      default: begin cr = 0;     cg = 65536; cb = 0;     end
    endcase
    return (r * cr + g * cg + b * cb + 32768) / 65536;
  endfunction

  // Output monitor for the 8-bit instance, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (was_stall) check("stall_hold", {23'b0, last_out, gray}, held);
        held = {23'b0, last_out, gray};
        was_stall = 1'b1;
        stall_cycles++;
      end else begin
        was_stall = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("gray", 32'(gray), 32'(e.gray));
          check("last", 32'(last_out), 32'(e.last));
          if (check_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
    end
  end

  // Present one pixel and hold it until accepted; called just after a rising
  // edge and returns just after the edge that took the pixel.
  task automatic send(input vec_t v);
    bit taken = 1'b0;
    exp_t e;
    in_valid = 1'b1;
    red      = v.r[7:0];
    green    = v.g[7:0];
    blue     = v.b[7:0];
    mode     = v.m;
    last_in  = v.l;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        e.gray = v.exp[7:0];
        e.last = v.l;
        e.cyc  = cyc;
        exp_q.push_back(e);
        taken = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!taken) check("accept_timeout", 32'(taken), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    last_in  = 1'b0;
  endtask

  // Wait (bounded) until every expected pixel has come out, then watch a few
  // more cycles so the monitor can flag anything extra.
  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  vec_t mode_tab[6];
  vec_t line_tab[5];
  vec_t w_tab[5];

  initial begin
    vec_t v;

    mode_tab[0] = '{16'd255, 16'd255, 16'd255, 2'd0, 1'b0, 16'd255};
    mode_tab[1] = '{16'd255, 16'd0,   16'd0,   2'd0, 1'b0, 16'd76};
    mode_tab[2] = '{16'd0,   16'd255, 16'd0,   2'd0, 1'b0, 16'd150};
    mode_tab[3] = '{16'd255, 16'd0,   16'd0,   2'd1, 1'b0, 16'd54};
    mode_tab[4] = '{16'd10,  16'd20,  16'd30,  2'd2, 1'b0, 16'd20};
    mode_tab[5] = '{16'd1,   16'd200, 16'd3,   2'd3, 1'b0, 16'd200};

    line_tab[0] = '{16'd100, 16'd100, 16'd100, 2'd0, 1'b0, 16'd100};
    line_tab[1] = '{16'd0,   16'd0,   16'd0,   2'd1, 1'b0, 16'd0};
    line_tab[2] = '{16'd0,   16'd255, 16'd0,   2'd0, 1'b0, 16'd150};
    line_tab[3] = '{16'd30,  16'd40,  16'd50,  2'd3, 1'b0, 16'd40};
    line_tab[4] = '{16'd255, 16'd0,   16'd0,   2'd1, 1'b1, 16'd54};

    w_tab[0] = '{16'd1023, 16'd1023, 16'd1023, 2'd0, 1'b0, 16'd1023};
    w_tab[1] = '{16'd1023, 16'd1023, 16'd1023, 2'd1, 1'b0, 16'd1023};
    w_tab[2] = '{16'd1023, 16'd1023, 16'd1023, 2'd2, 1'b0, 16'd1023};
    w_tab[3] = '{16'd1023, 16'd1023, 16'd1023, 2'd3, 1'b0, 16'd1023};
    w_tab[4] = '{16'd1023, 16'd0,    16'd0,    2'd0, 1'b0, 16'd306};

    rst = 1'b0;
    in_valid = 1'b0; red = '0; green = '0; blue = '0; mode = '0; last_in = 1'b0;
    out_ready = 1'b1;
    in_valid10 = 1'b0; red10 = '0; green10 = '0; blue10 = '0; mode10 = '0;
    out_ready10 = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_gray",      32'(gray),      32'd0);
    check("rst_last",      32'(last_out),  32'd0);
    rst = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_in_ready",  32'(in_ready),  32'd1);
      check("idle_out_valid", 32'(out_valid), 32'd0);
      check("idle_busy",      32'(busy),      32'd0);
    end
    @(posedge clk);
    #1;

    // Mode coverage, back to back, latency checked
    mon_en = 1'b1;
    check_lat = 1'b1;
    for (int i = 0; i < 6; i++) send(mode_tab[i]);
    drain();

    // Sideband with a one-cycle gap after pixel 2
    for (int i = 0; i < 5; i++) begin
      send(line_tab[i]);
      if (i == 1) begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    // Backpressure: out_ready low for cycles 4..7 of the burst
    check_lat = 1'b0;
    stall_cycles = 0;
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 8; i++) begin
      v.r = 16'($urandom_range(0, 255));
      v.g = 16'($urandom_range(0, 255));
      v.b = 16'($urandom_range(0, 255));
      v.m = 2'($urandom_range(0, 3));
      v.l = (i == 7);
      v.exp = 16'(model_gray(int'(v.r), int'(v.g), int'(v.b), int'(v.m)));
      send(v);
    end
    drain();
    check("stall_seen", 32'(stall_cycles > 0), 32'd1);

    // Reset in mid-stream
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) send(mode_tab[i + 1]);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    check("pre_rst_busy",      32'(busy),      32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_gray",      32'(gray),      32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      check("post_rst_busy",     32'(busy),      32'd0);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    check_lat = 1'b1;
    send(mode_tab[3]);
    drain();

    // 10-bit width, one pixel per cycle
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        in_valid10 = 1'b1;
        red10   = w_tab[i].r[9:0];
        green10 = w_tab[i].g[9:0];
        blue10  = w_tab[i].b[9:0];
        mode10  = w_tab[i].m;
      end else begin
        in_valid10 = 1'b0;
      end
      @(negedge clk);
      if (i >= 3) begin
        check("w10_valid", 32'(out_valid10), 32'd1);
        check("w10_gray",  32'(gray10),      32'(w_tab[i - 3].exp));
      end else begin
        check("w10_idle",  32'(out_valid10), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("w10_done", 32'(busy10), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb2gray_pipe.md
Name: rgb2gray_pipe

Overview:
- Parametrised, fully pipelined RGB-to-grayscale converter with valid/ready flow control on both sides.
- Successor to the fixed 8-bit, single-formula converter.
- Adds selectable luma coefficient sets per pixel, round-to-nearest, configurable pixel width, backpressure and end-of-line sideband.
- Sits between the pixel source (camera/frame reader) and downstream gray-domain filters.

Parameters:
- DATA_W, 8, bits per colour channel and per gray output (legal 4..16).
- COEF_W, 17, width of unsigned Q16 coefficients; fixed so that 65536 is representable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset (0 = reset).
- in_valid  input  1  input pixel valid.
- in_ready  output  1  block can accept a pixel this cycle.
- red_in  input  DATA_W  red channel.
- green_in  input  DATA_W  green channel.
- blue_in  input  DATA_W  blue channel.
- mode_in  input  2  coefficient set for this pixel.
- last_in  input  1  end-of-line marker, carried with the pixel.
- out_valid  output  1  gray_out valid.
- out_ready  input  1  downstream accepts gray_out.
- gray_out  output  DATA_W  luma result.
- last_out  output  1  last_in delayed with its pixel.
- busy  output  1  any pipeline stage holds a valid pixel.

Behaviour:
- Reset (rst=0, async):
  - all stage valid bits, out_valid, last_out and busy go to 0.
  - gray_out and data registers go to 0.
  - Reset mid-stream discards every in-flight pixel; no partial output after release.
- Transfers:
  - Input transfer occurs when in_valid & in_ready at a clock edge.
  - Output transfer occurs when out_valid & out_ready at a clock edge.
- Pipeline enable: advance = ~out_valid | out_ready. The whole pipeline shifts on advance; all stages hold otherwise. in_ready = advance (combinational from out_ready).
- S1: register R, G, B, mode_in and last_in, and set v1 = in_valid & in_ready.
- S2 products:
  - pr = R*cr, pg = G*cg, pb = B*cb, with coefficients selected by the S1 mode.
  - Each product is DATA_W+COEF_W bits, unsigned.
- S3:
  - sum = pr+pg+pb+32768, width DATA_W+COEF_W+2.
  - gray_out = sum[DATA_W+15:16].
  - Coefficients in every set sum to exactly 65536, so the result never exceeds 2^DATA_W-1. No saturation logic is needed.
- Latency: exactly 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 pixel/cycle.
- Coefficient sets (cr, cg, cb):
  - 0 = BT.601: 19595, 38470, 7471.
  - 1 = BT.709: 13933, 46871, 4732.
  - 2 = average: 21845, 21845, 21846.
  - 3 = green passthrough: 0, 65536, 0.
- mode is captured per pixel. Mixed modes in consecutive pixels are legal, and each pixel uses its own mode.
- Stall: while out_valid=1 and out_ready=0:
  - gray_out, last_out and all stages hold stable.
  - in_ready=0, so no input is lost or duplicated.
- Bubbles: in_valid=0 inserts an empty slot. Empty slots propagate and are never output.
- Ordering: pixels leave in strict acceptance order. last_out aligns with its own pixel.
- busy = v1 | v2 | out_valid.

Test Plan:
- Reset then idle: rst=0→1, in_valid=0 for 10 cycles → out_valid=0, busy=0, in_ready=1 throughout.
- Mode coverage, DATA_W=8, out_ready=1, one pixel per cycle:
  - (255,255,255,m0) → 255.
  - (255,0,0,m0) → 76.
  - (0,255,0,m0) → 150.
  - (255,0,0,m1) → 54.
  - (10,20,30,m2) → 20.
  - (1,200,3,m3) → 200.
  - Each result appears exactly 3 cycles after its input, in order.
- Backpressure: stream 8 random pixels with out_ready low for cycles 4–7 → in_ready=0 whenever out_valid=1 and out_ready=0, gray_out stable while stalled, all 8 results match the model, no drop or duplicate.
- Sideband: 5-pixel line with last_in=1 on pixel 5 and a one-cycle in_valid gap after pixel 2 → last_out=1 only with the 5th output.
- Reset mid-operation: accept 3 pixels, assert rst=0 on the next cycle → out_valid and busy drop to 0 immediately. After release, no stale output appears and a fresh pixel returns after 3 cycles.
- Width: DATA_W=10, (1023,1023,1023) in all four modes → 1023. (1023,0,0,m0) → 306.
